// File: rtl/slon_stream_pkg.sv
// Shared types and helpers for the slon sample-stream generator.
// Optional LFSR source is enabled by defining SLON_STREAM_GEN_LFSR_EN.
package slon_stream_pkg;

    localparam int unsigned MAX_DOUT_WIDTH = 32;
    localparam int unsigned MAX_LEVEL_WIDTH = 32;

    typedef logic [MAX_DOUT_WIDTH-1:0]  Data_t;
    typedef logic [MAX_LEVEL_WIDTH-1:0] Level_t;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_HOLD  = 2'd3
    } Mode_t;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Maximal-length Fibonacci tap masks; bit n-1 set for polynomial term x^n.
    function automatic Data_t lfsr_taps(input int unsigned width);
        Data_t taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/slon_sync_fifo.sv
// Single-clock sample buffer with first-word-fall-through head and occupancy count.
module slon_sync_fifo
    import slon_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == LVL_FULL);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A write into a full buffer is accepted only when a pop frees a slot in the same cycle.
    assign do_wr = wr_en & (~full | rd_en);
    assign do_rd = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/slon_stream_gen.sv
// Sample stream generator: buffered counter/LFSR/constant source drained at out_clk ticks.
// Define SLON_STREAM_GEN_LFSR_EN to build the LFSR source; otherwise mode 1 acts as the counter.
module slon_stream_gen
    import slon_stream_pkg::*;
#(
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned CLK_FACTOR = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [DOUT_WIDTH-1:0]         seed,
    input  logic                          clr_underrun,
    output logic                          out_clk,
    output logic [DOUT_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PH_W = $clog2(CLK_FACTOR);
    localparam int unsigned LW   = level_width(FIFO_DEPTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_FACTOR - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_FACTOR / 2 - 1);
`ifdef SLON_STREAM_GEN_LFSR_EN
    localparam logic [DOUT_WIDTH-1:0] LFSR_TAPS = DOUT_WIDTH'(lfsr_taps(DOUT_WIDTH));
`endif

    typedef logic [DOUT_WIDTH-1:0] sample_t;

    logic [PH_W-1:0] phase_q, phase_d;
    logic            out_clk_q, out_clk_d;
    logic            en_d_q;
    sample_t         src_q, src_d;
    sample_t         dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            underrun_q, underrun_d;

    Mode_t           mode_e;
    sample_t         seed_load;
    sample_t         head;
    logic            tick, en_rise, wr_en, rd_en, full, empty;
    logic [LW-1:0]   level;

    assign mode_e  = Mode_t'(mode);
    assign tick    = (phase_q == PH_LAST);
    assign en_rise = en & ~en_d_q;
    assign rd_en   = tick & ~empty;
    assign wr_en   = en & ~en_rise & (~full | rd_en);

`ifdef SLON_STREAM_GEN_LFSR_EN
    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    assign seed_load = (mode_e == MODE_LFSR && seed == '0) ? sample_t'(1) : seed;
`else
    assign seed_load = seed;
`endif

    always_comb begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

        out_clk_d = out_clk_q;
        if (phase_q == PH_HALF)      out_clk_d = 1'b1;
        else if (phase_q == PH_LAST) out_clk_d = 1'b0;

        src_d = src_q;
        if (en_rise) begin
            src_d = seed_load;
        end else if (wr_en) begin
            unique case (mode_e)
                MODE_CNT:   src_d = src_q + 1'b1;
`ifdef SLON_STREAM_GEN_LFSR_EN
                MODE_LFSR:  src_d = {src_q[DOUT_WIDTH-2:0], ^(src_q & LFSR_TAPS)};
`else
                MODE_LFSR:  src_d = src_q + 1'b1;
`endif
                MODE_CONST: src_d = seed;
                default:    src_d = src_q;
            endcase
        end

        dout_d       = rd_en ? head : dout_q;
        dout_valid_d = tick ? ~empty : dout_valid_q;

        underrun_d = underrun_q;
        if (tick & en & empty)  underrun_d = 1'b1;
        else if (clr_underrun)  underrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            out_clk_q    <= 1'b0;
            en_d_q       <= 1'b0;
            src_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            out_clk_q    <= out_clk_d;
            en_d_q       <= en;
            src_q        <= src_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    slon_sync_fifo #(
        .WIDTH (DOUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (src_q),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_clk    = out_clk_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign underrun   = underrun_q;
    assign fifo_level = level;

endmodule

// File: doc/slon_stream_gen.md
SLON_STREAM_GEN -- requirements
Module: slon_stream_gen

Interface
REQ-001 Parameter DOUT_WIDTH, default 8: sample width; legal 4..32.
REQ-002 Parameter CLK_FACTOR, default 8: clk cycles per out_clk period; even, >=4.
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer depth; power of 2, >=4.
REQ-004 Port clk  in  1  single system clock; all logic on posedge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port en  in  1  sample generation enable.
REQ-007 Port mode  in  2  source select: 0 counter, 1 LFSR, 2 constant (seed), 3 hold last.
REQ-008 Port seed  in  DOUT_WIDTH  start value loaded on en rise.
REQ-009 Port clr_underrun  in  1  single-cycle pulse clearing underrun.
REQ-010 Port out_clk  out  1  divided output clock.
REQ-011 Port dout  out  DOUT_WIDTH  output sample, registered.
REQ-012 Port dout_valid  out  1  dout holds a sample popped at the last tick.
REQ-013 Port underrun  out  1  sticky: tick found buffer empty while en=1.
REQ-014 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-015 Phase counter SHALL count 0..CLK_FACTOR-1 and wrap to 0; no extra state at CLK_FACTOR.
REQ-016 out_clk SHALL be set on the cycle after count CLK_FACTOR/2-1 and cleared on the cycle after count CLK_FACTOR-1: period CLK_FACTOR, 50% duty.
REQ-017 tick SHALL be asserted on count CLK_FACTOR-1, so dout changes on out_clk falling edge and is stable at rising edge.
REQ-018 Source register SHALL load seed on the cycle en is sampled rising (en & !en_d); in LFSR mode, seed 0 SHALL load 1.
REQ-019 Producer SHALL write the source value into the buffer on every cycle with en=1, not en-rise, and buffer not full; source SHALL advance only on a write.
REQ-020 Advance rules: counter +1 modulo 2^DOUT_WIDTH; LFSR one Fibonacci shift with package taps; constant reloads seed; hold keeps value.
REQ-021 Buffer full SHALL stall producer without dropping or skipping samples; the output sequence SHALL be contiguous.
REQ-022 On tick with buffer non-empty: pop, dout <= head, dout_valid <= 1; on tick with buffer empty: dout holds, dout_valid <= 0.
REQ-023 underrun SHALL set on tick & en & empty; clr_underrun SHALL clear it; simultaneous set and clear: set wins.
REQ-024 Simultaneous write and pop SHALL leave fifo_level unchanged; the write SHALL succeed when full only if a pop occurs the same cycle.
REQ-025 en deassert SHALL stop writes immediately; buffered samples SHALL still drain at ticks; underrun SHALL not set while en=0.
REQ-026 mode change while en=1 SHALL apply to the next advance, continuing from the current source value.

Reset
REQ-027 rst_n low SHALL asynchronously force: out_clk 0, dout 0, dout_valid 0, underrun 0, fifo_level 0, phase counter 0, source 0, en_d 0, pointers 0.
REQ-028 Release SHALL be synchronous to clk; the first phase count 0 SHALL be the first clk after release; reset mid-stream SHALL discard buffered samples.

Configuration
REQ-029 Macro SLON_STREAM_GEN_LFSR_EN defined: mode 1 SHALL be the LFSR per REQ-020.
REQ-030 Macro not defined: no LFSR logic SHALL exist; mode 1 SHALL behave as mode 0 (counter), including seed 0 loading 0.

Structure
REQ-031 Package slon_stream_pkg SHALL hold the Mode_t enum, a lfsr_taps(width) function for widths 4..32, and the Data_t/Level_t width helpers.
REQ-032 Buffer SHALL be a sub-module slon_sync_fifo (one clk, rst_n, wr_en/rd_en, full/empty/level); its depth SHALL be parametrised, not an IP core.

Verification
REQ-033 Reset: rst_n low mid-run, no clk edge -> all outputs 0 within same delta; release -> out_clk first rises after 4 clk (CLK_FACTOR=8).
REQ-034 Counter, seed=8'hFE, en held -> dout FE, FF, 00, 01 at consecutive ticks 8 clk apart; out_clk high 4, low 4.
REQ-035 LFSR_EN defined, mode 1, seed 0 -> first dout 8'h01, then package-tap sequence; macro undefined -> 00, 01, 02.
REQ-036 en held, FIFO_DEPTH=16 -> fifo_level saturates at 16; dout sequence has no gaps over 40 ticks.
REQ-037 en low after fill -> 16 valid samples drained, then dout_valid 0, dout holds last value, underrun 0.
REQ-038 en raised 1 cycle before tick -> underrun 1; clr_underrun pulse on a later underrun-setting tick -> underrun stays 1.
